// File: rtl/button_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// button_pkg: debounce FSM state encoding and default configuration. Rev 1.0
//------------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_e;

  localparam int DEF_N_BTN           = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_ACTIVE_HIGH     = 1;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
//------------------------------------------------------------------------------
// button_channel: one button's synchroniser, debounce FSM and auto-repeat
// (auto-repeat only when BTN_AUTOREPEAT_EN is defined). Rev 1.0
//------------------------------------------------------------------------------
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ACTIVE_HIGH     = DEF_ACTIVE_HIGH,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  if ((SYNC_STAGES < 2) || (DEBOUNCE_CYCLES < 1) ||
      (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_cfg
    $error("button_channel: illegal parameter set");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  btn_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   sample;

  // Polarity is normalised before the first synchroniser stage.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], (ACTIVE_HIGH != 0) ? btn_raw : ~btn_raw};
  end

  assign sample  = sync_q[SYNC_STAGES-1];
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (sample) begin
          state_d = PRESS_PEND;
          cnt_d   = '0;
        end
      end
      PRESS_PEND: begin
        if (!sample) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (!sample) begin
          state_d = RELEASE_PEND;
          cnt_d   = '0;
        end
      end
      RELEASE_PEND: begin
        if (sample) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int               RPT_MAX   = max_int(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int               RPT_W     = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             repeat_q, repeat_d;

  // Down-counter: holds the number of edges left before the next repeat pulse.
  always_comb begin
    rpt_d    = '0;
    repeat_d = 1'b0;
    if ((state_d == PRESSED) && (state_q != PRESSED)) begin
      rpt_d = RPT_FIRST;
    end else if ((state_d == PRESSED) && (state_q == PRESSED)) begin
      if (rpt_q == '0) begin
        repeat_d = 1'b1;
        rpt_d    = RPT_NEXT;
      end else begin
        rpt_d = rpt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q    <= '0;
      repeat_q <= 1'b0;
    end else begin
      rpt_q    <= rpt_d;
      repeat_q <= repeat_d;
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
//------------------------------------------------------------------------------
// button_conditioner: N_BTN debounced buttons with press/release/repeat pulses;
// auto-repeat built only when BTN_AUTOREPEAT_EN is defined. Rev 1.0
//------------------------------------------------------------------------------
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN           = DEF_N_BTN,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ACTIVE_HIGH     = DEF_ACTIVE_HIGH,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] buttons_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_press
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_HIGH    (ACTIVE_HIGH),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk_in       (clk_in),
      .rst_n        (rst_n),
      .btn_raw      (buttons_in[i]),
      .level        (btn_level[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i]),
      .repeat_pulse (btn_repeat[i])
    );
  end

  // OR of registered pulses only, so nothing combinational reaches buttons_in.
  assign any_press = |btn_press;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// tb_button_conditioner: directed scenarios plus randomized run against a
// run-length debounce model. Rev 1.0
//------------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic         clk_in = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] buttons_in = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic         any_press;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  button_conditioner #(
    .N_BTN(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .ACTIVE_HIGH(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .buttons_in(buttons_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .any_press(any_press)
  );

  // Model: a level flips once D+1 consecutive synchronised samples disagree with it.
  logic [N-1:0] m_level, m_press, m_release, m_repeat;
  int           m_run[N];
  int           m_anchor[N];
  int           edge_no;
  logic [N-1:0] m_pipe[$];

  function automatic void model_reset();
    m_level = '0; m_press = '0; m_release = '0; m_repeat = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0;
      m_anchor[i] = 0;
    end
    m_pipe.delete();
    for (int i = 0; i < S; i++) m_pipe.push_back('0);
  endfunction

  function automatic void model_edge(input logic [N-1:0] raw);
    logic [N-1:0] s;
    bit prev_p, post_p;
    int d;
    edge_no++;
    s = m_pipe.pop_front();
    m_pipe.push_back(raw);
    m_press = '0; m_release = '0; m_repeat = '0;
    for (int i = 0; i < N; i++) begin
      prev_p = m_level[i] && (m_run[i] == 0);
      if (s[i] != m_level[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == D + 1) begin
        m_level[i] = ~m_level[i];
        m_run[i] = 0;
        if (m_level[i]) m_press[i] = 1'b1;
        else m_release[i] = 1'b1;
      end
      post_p = m_level[i] && (m_run[i] == 0);
      if (post_p && !prev_p) m_anchor[i] = edge_no;
      else if (post_p && prev_p && REP_EN) begin
        d = edge_no - m_anchor[i];
        if (d >= RD && ((d - RD) % RP) == 0) m_repeat[i] = 1'b1;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk_in);
    if (rst_n) model_edge(buttons_in);
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    buttons_in = '0;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({btn_level, btn_press, btn_release, btn_repeat, any_press} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got lvl=%b prs=%b rel=%b rep=%b any=%b exp all 0",
               btn_level, btn_press, btn_release, btn_repeat, any_press);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clean_press();
    buttons_in[0] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step();
      checks++;
      if (btn_level[0] !== (j >= 6) || btn_press[0] !== (j == 6) || any_press !== (j == 6)) begin
        errors++;
        $display("FAIL clean_press j=%0d got lvl=%b prs=%b any=%b exp lvl=%b prs=%b",
                 j, btn_level[0], btn_press[0], any_press, j >= 6, j == 6);
      end
    end
  endtask

  task automatic test_bounce();
    int presses = 0;
    for (int j = 0; j < 14; j++) begin
      buttons_in[1] = (j != 3);
      step();
      presses += int'(btn_press[1]);
      checks++;
      if (btn_level[1] !== (j >= 10) || btn_press[1] !== (j == 10) || btn_release[1] !== 1'b0) begin
        errors++;
        $display("FAIL bounce j=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=0",
                 j, btn_level[1], btn_press[1], btn_release[1], j >= 10, j == 10);
      end
    end
    checks++;
    if (presses != 1) begin
      errors++;
      $display("FAIL bounce_count got %0d presses exp 1", presses);
    end
  endtask

  task automatic test_release();
    buttons_in[2] = 1'b1;
    repeat (8) step();
    buttons_in[2] = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      checks++;
      if (btn_level[2] !== (j < 6) || btn_release[2] !== (j == 6) || btn_press[2] !== 1'b0) begin
        errors++;
        $display("FAIL release j=%0d got lvl=%b rel=%b prs=%b exp lvl=%b rel=%b prs=0",
                 j, btn_level[2], btn_release[2], btn_press[2], j < 6, j == 6);
      end
    end
  endtask

  task automatic test_simultaneous();
    buttons_in = '0;
    repeat (10) step();
    buttons_in = 4'b1111;
    for (int j = 0; j < 10; j++) begin
      step();
      checks++;
      if (btn_press !== ((j == 6) ? 4'b1111 : 4'b0000) || any_press !== (j == 6) ||
          btn_level !== ((j >= 6) ? 4'b1111 : 4'b0000)) begin
        errors++;
        $display("FAIL simultaneous j=%0d got prs=%b any=%b lvl=%b exp prs=%b any=%b",
                 j, btn_press, any_press, btn_level, (j == 6) ? 4'b1111 : 4'b0000, j == 6);
      end
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release, btn_repeat, any_press} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async got lvl=%b prs=%b any=%b exp all 0", btn_level, btn_press, any_press);
    end
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step();
      checks++;
      if (btn_level !== ((j >= 6) ? 4'b1111 : 4'b0000) || btn_press !== ((j == 6) ? 4'b1111 : 4'b0000)) begin
        errors++;
        $display("FAIL reset_mid_repress j=%0d got lvl=%b prs=%b", j, btn_level, btn_press);
      end
    end
  endtask

  task automatic test_autorepeat();
    logic [N-1:0] exp_rep;
    buttons_in = '0;
    repeat (10) step();
    for (int j = 0; j < 35; j++) begin
      buttons_in[3] = (j < 21);
      step();
      exp_rep = {REP_EN && (j == 14 || j == 17 || j == 20), 3'b000};
      checks++;
      if (btn_repeat !== exp_rep || btn_level[3] !== (j >= 6 && j < 27) ||
          btn_press[3] !== (j == 6) || btn_release[3] !== (j == 27)) begin
        errors++;
        $display("FAIL autorepeat j=%0d got rep=%b lvl=%b prs=%b rel=%b exp rep=%b",
                 j, btn_repeat, btn_level[3], btn_press[3], btn_release[3], exp_rep);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release, btn_repeat, any_press} !== '0) begin
          errors++;
          $display("FAIL random_reset c=%0d got lvl=%b prs=%b exp 0", c, btn_level, btn_press);
        end
        @(negedge clk_in);
        rst_n = 1'b1;
      end
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) buttons_in[i] = ~buttons_in[i];
      step();
      checks++;
      if (btn_level !== m_level || btn_press !== m_press || btn_release !== m_release ||
          btn_repeat !== m_repeat || any_press !== (|m_press) || (btn_press & btn_release) !== '0) begin
        errors++;
        $display("FAIL random c=%0d got lvl=%b prs=%b rel=%b rep=%b any=%b exp lvl=%b prs=%b rel=%b rep=%b",
                 c, btn_level, btn_press, btn_release, btn_repeat, any_press,
                 m_level, m_press, m_release, m_repeat);
      end
    end
  endtask

  initial begin
    edge_no = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid();
    test_autorepeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
